// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache block requests onto one main-memory port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking instead of fixed D-cache priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IC_READ,
  input  logic [ADDR_W-1:0] IC_BLOCK_ADDR,
  output logic              IC_BUSYWAIT,
  output logic [DATA_W-1:0] IC_READ_DATA,
  input  logic              DC_READ,
  input  logic              DC_WRITE,
  input  logic [ADDR_W-1:0] DC_BLOCK_ADDR,
  input  logic [DATA_W-1:0] DC_WRITE_DATA,
  output logic              DC_BUSYWAIT,
  output logic [DATA_W-1:0] DC_READ_DATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_BLOCK_ADDR,
  output logic [DATA_W-1:0] MEM_WRITE_DATA,
  input  logic              MEM_BUSYWAIT,
  input  logic [DATA_W-1:0] MEM_READ_DATA
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic own_dc, op_wr, drop;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ic_data, dc_data;
  logic ic_req, dc_req, grant_dc, busy, own_req;
  assign ic_req = IC_READ;
  assign dc_req = DC_READ || DC_WRITE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_dc;
  assign grant_dc = dc_req && (!ic_req || !last_dc);
`else
  assign grant_dc = dc_req;
`endif
  assign busy           = (state == ISSUE || state == WAIT) && !RESET;
  assign MEM_READ       = busy && !op_wr;
  assign MEM_WRITE      = busy && op_wr;
  assign MEM_BLOCK_ADDR = busy ? addr_q : '0;
  assign MEM_WRITE_DATA = busy ? wdata_q : '0;
  assign IC_BUSYWAIT    = ic_req && !(state == RESP && !own_dc);
  assign DC_BUSYWAIT    = dc_req && !(state == RESP && own_dc);
  assign IC_READ_DATA   = ic_data;
  assign DC_READ_DATA   = dc_data;
  assign own_req        = own_dc ? dc_req : ic_req;
  // drop remembers an owner that let go mid-flight, so its stale response is never stored
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      own_dc  <= 1'b0;
      op_wr   <= 1'b0;
      drop    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ic_data <= '0;
      dc_data <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_dc <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (ic_req || dc_req) begin
          state   <= ISSUE;
          own_dc  <= grant_dc;
          op_wr   <= grant_dc && DC_WRITE;
          drop    <= 1'b0;
          addr_q  <= grant_dc ? DC_BLOCK_ADDR : IC_BLOCK_ADDR;
          wdata_q <= (grant_dc && DC_WRITE) ? DC_WRITE_DATA : '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_dc <= grant_dc;
`endif
        end
        ISSUE: begin
          state <= WAIT;
          drop  <= drop || !own_req;
        end
        WAIT: begin
          drop <= drop || !own_req;
          if (!MEM_BUSYWAIT) begin
            state <= RESP;
            if (!op_wr && own_req && !drop) begin
              if (own_dc) dc_data <= MEM_READ_DATA;
              else ic_data <= MEM_READ_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;
  logic         CLK = 1'b0, RESET = 1'b1;
  logic         IC_READ, IC_BUSYWAIT, DC_READ, DC_WRITE, DC_BUSYWAIT;
  logic         MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]  IC_BLOCK_ADDR, DC_BLOCK_ADDR, MEM_BLOCK_ADDR;
  logic [127:0] IC_READ_DATA, DC_WRITE_DATA, DC_READ_DATA, MEM_WRITE_DATA, MEM_READ_DATA;
  int checks = 0, errors = 0, cnt = 0, wait_n = 0, mc, lat;
  logic [157:0] mem_q[$];
  logic [127:0] ic_q[$], dc_q[$];
  logic prev_act = 1'b0, mon_act;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .IC_READ(IC_READ), .IC_BLOCK_ADDR(IC_BLOCK_ADDR), .IC_BUSYWAIT(IC_BUSYWAIT), .IC_READ_DATA(IC_READ_DATA),
    .DC_READ(DC_READ), .DC_WRITE(DC_WRITE), .DC_BLOCK_ADDR(DC_BLOCK_ADDR), .DC_WRITE_DATA(DC_WRITE_DATA),
    .DC_BUSYWAIT(DC_BUSYWAIT), .DC_READ_DATA(DC_READ_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ_DATA(MEM_READ_DATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] rd_of(input logic [27:0] a);
    return (a == 28'h10) ? {16{8'hA5}} : {4{4'hC, a}};
  endfunction

  // memory stalls until the request has been visible for wait_n edges
  always @(posedge CLK) cnt <= (MEM_READ || MEM_WRITE) ? cnt + 1 : 0;
  assign MEM_BUSYWAIT  = (MEM_READ || MEM_WRITE) && (cnt < wait_n);
  assign MEM_READ_DATA = rd_of(MEM_BLOCK_ADDR);

  task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  always @(negedge CLK) begin
    mon_act = MEM_READ || MEM_WRITE;
    if (mon_act && !prev_act) begin
      if (mem_q.size() == 0) bad("mem_unexpected_request");
      else chk("mem_req", {MEM_WRITE, MEM_READ, MEM_BLOCK_ADDR, MEM_WRITE_DATA}, mem_q.pop_front());
    end
    prev_act = mon_act;
    if (IC_READ && !IC_BUSYWAIT) begin
      if (ic_q.size() == 0) bad("ic_unexpected_response");
      else chk("ic_data", IC_READ_DATA, ic_q.pop_front());
    end
    if ((DC_READ || DC_WRITE) && !DC_BUSYWAIT) begin
      if (dc_q.size() == 0) bad("dc_unexpected_response");
      else chk("dc_data", DC_READ_DATA, dc_q.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input bit dc, output int mem_cyc, output int lt);
    bit done = 1'b0;
    mem_cyc = 0;
    lt = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      lt++;
      if (MEM_READ || MEM_WRITE) mem_cyc++;
      done = dc ? !DC_BUSYWAIT : !IC_BUSYWAIT;
    end
    if (!done) bad("wait_done_timeout");
  endtask

  task automatic serve_all();
    bit ic_d, dc_d;
    for (int i = 0; i < 200 && (IC_READ || DC_READ || DC_WRITE); i++) begin
      @(negedge CLK);
      ic_d = IC_READ && !IC_BUSYWAIT;
      dc_d = (DC_READ || DC_WRITE) && !DC_BUSYWAIT;
      if (ic_d || dc_d) begin
        step();
        if (ic_d) IC_READ = 1'b0;
        if (dc_d) begin
          DC_READ  = 1'b0;
          DC_WRITE = 1'b0;
        end
      end
    end
    if (IC_READ || DC_READ || DC_WRITE) bad("serve_timeout");
  endtask

  initial begin
    IC_READ = 0; DC_READ = 0; DC_WRITE = 0;
    IC_BLOCK_ADDR = '0; DC_BLOCK_ADDR = '0; DC_WRITE_DATA = '0;
    step();
    step();
    IC_READ = 1'b1;
    @(negedge CLK);
    chk("rst_mem_read", MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_mem_addr", MEM_BLOCK_ADDR, 0);
    chk("rst_mem_wdata", MEM_WRITE_DATA, 0);
    chk("rst_ic_data", IC_READ_DATA, 0);
    chk("rst_dc_data", DC_READ_DATA, 0);
    chk("rst_ic_busy", IC_BUSYWAIT, 1);
    chk("rst_dc_busy", DC_BUSYWAIT, 0);
    step();
    RESET = 1'b0;
    IC_READ = 1'b0;
    @(negedge CLK);
    chk("rst_priority_idle", MEM_READ, 0);

    // IC read, 3 memory wait cycles
    wait_n = 3;
    mem_q.push_back({1'b0, 1'b1, 28'h10, 128'h0});
    ic_q.push_back({16{8'hA5}});
    step();
    IC_READ = 1'b1; IC_BLOCK_ADDR = 28'h10;
    wait_done(1'b0, mc, lat);
    chk("ic_mem_read_cycles", mc, 4);
    chk("ic_latency", lat, 6);
    step();
    IC_READ = 1'b0;
    @(negedge CLK);
    chk("ic_data_hold", IC_READ_DATA, {16{8'hA5}});

    // tie: DC write wins, then DC re-requests against the still-pending IC
    wait_n = 1;
    mem_q.push_back({1'b1, 1'b0, 28'h20, 128'h1234});
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    mem_q.push_back({1'b0, 1'b1, 28'h30, 128'h0});
    mem_q.push_back({1'b0, 1'b1, 28'h21, 128'h0});
`else
    mem_q.push_back({1'b0, 1'b1, 28'h21, 128'h0});
    mem_q.push_back({1'b0, 1'b1, 28'h30, 128'h0});
`endif
    dc_q.push_back(128'h0);
    dc_q.push_back(rd_of(28'h21));
    ic_q.push_back(rd_of(28'h30));
    step();
    IC_READ = 1'b1; IC_BLOCK_ADDR = 28'h30;
    DC_WRITE = 1'b1; DC_BLOCK_ADDR = 28'h20; DC_WRITE_DATA = 128'h1234;
    wait_done(1'b1, mc, lat);
    step();
    DC_WRITE = 1'b0; DC_READ = 1'b1; DC_BLOCK_ADDR = 28'h21; DC_WRITE_DATA = '0;
    @(negedge CLK);
    chk("tie_idle_gap", {MEM_READ, MEM_WRITE}, 0);
    @(negedge CLK);
    chk("tie_second_read", MEM_READ, 1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    chk("tie_second_addr", MEM_BLOCK_ADDR, 28'h30);
`else
    chk("tie_second_addr", MEM_BLOCK_ADDR, 28'h21);
`endif
    serve_all();

    // write-back then read, zero-wait memory
    wait_n = 0;
    mem_q.push_back({1'b1, 1'b0, 28'h7, 128'hDEAD_BEEF});
    dc_q.push_back(rd_of(28'h21));
    step();
    DC_WRITE = 1'b1; DC_BLOCK_ADDR = 28'h7; DC_WRITE_DATA = 128'hDEAD_BEEF;
    wait_done(1'b1, mc, lat);
    chk("wb_latency", lat, 4);
    chk("wb_mem_cycles", mc, 2);
    mem_q.push_back({1'b0, 1'b1, 28'h3, 128'h0});
    dc_q.push_back(rd_of(28'h3));
    step();
    DC_WRITE = 1'b0; DC_READ = 1'b1; DC_BLOCK_ADDR = 28'h3; DC_WRITE_DATA = '0;
    serve_all();

    // address change during WAIT is ignored
    wait_n = 3;
    mem_q.push_back({1'b0, 1'b1, 28'h5, 128'h0});
    dc_q.push_back(rd_of(28'h5));
    step();
    DC_READ = 1'b1; DC_BLOCK_ADDR = 28'h5;
    repeat (3) @(negedge CLK);
    step();
    DC_BLOCK_ADDR = 28'h9;
    @(negedge CLK);
    chk("latched_addr", MEM_BLOCK_ADDR, 28'h5);
    serve_all();

    // reset pulse during WAIT
    wait_n = 5;
    mem_q.push_back({1'b0, 1'b1, 28'h44, 128'h0});
    step();
    IC_READ = 1'b1; IC_BLOCK_ADDR = 28'h44;
    repeat (3) @(negedge CLK);
    step();
    RESET = 1'b1; IC_READ = 1'b0;
    @(negedge CLK);
    chk("in_reset_mem_read", MEM_READ, 0);
    chk("in_reset_mem_addr", MEM_BLOCK_ADDR, 0);
    step();
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_reset_mem_read", MEM_READ, 0);
    chk("post_reset_ic_data", IC_READ_DATA, 0);
    chk("post_reset_dc_data", DC_READ_DATA, 0);
    mem_q.push_back({1'b0, 1'b1, 28'h10, 128'h0});
    ic_q.push_back({16{8'hA5}});
    step();
    IC_READ = 1'b1; IC_BLOCK_ADDR = 28'h10;
    serve_all();

    // IC drops during WAIT: transaction completes, data untouched
    wait_n = 3;
    mem_q.push_back({1'b0, 1'b1, 28'h50, 128'h0});
    step();
    IC_READ = 1'b1; IC_BLOCK_ADDR = 28'h50;
    repeat (3) @(negedge CLK);
    step();
    IC_READ = 1'b0;
    begin
      bit ended = 1'b0;
      for (int i = 0; i < 20 && !ended; i++) begin
        @(negedge CLK);
        ended = !MEM_READ;
      end
      if (!ended) bad("drop_timeout");
    end
    chk("drop_data_resp", IC_READ_DATA, {16{8'hA5}});
    @(negedge CLK);
    chk("drop_idle", {MEM_READ, MEM_WRITE}, 0);
    chk("drop_data_idle", IC_READ_DATA, {16{8'hA5}});

    repeat (2) @(negedge CLK);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("ic_q_drained", ic_q.size(), 0);
    chk("dc_q_drained", dc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, block-address width.
REQ-002 SHALL have parameter DATA_W, default 128, block width.
REQ-003 SHALL have port CLK  in  1  clock, rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports IC_READ in 1 and IC_BLOCK_ADDR in ADDR_W, the I-cache block-fetch request.
REQ-006 SHALL have ports IC_BUSYWAIT out 1 and IC_READ_DATA out DATA_W, the I-cache stall and returned block.
REQ-007 SHALL have ports DC_READ in 1, DC_WRITE in 1, DC_BLOCK_ADDR in ADDR_W and DC_WRITE_DATA in DATA_W, the D-cache fetch/write-back request.
REQ-008 SHALL have ports DC_BUSYWAIT out 1 and DC_READ_DATA out DATA_W, the D-cache stall and returned block.
REQ-009 SHALL have ports MEM_READ out 1, MEM_WRITE out 1, MEM_BLOCK_ADDR out ADDR_W and MEM_WRITE_DATA out DATA_W, the main-memory request.
REQ-010 SHALL have ports MEM_BUSYWAIT in 1 and MEM_READ_DATA in DATA_W, the main-memory response.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with all state, owner and data registers updated only on the CLK rising edge.
REQ-012 SHALL, in IDLE at an edge with any pending request, select one owner (IC or DC) per REQ-022, latch owner/op/address/write-data, and enter ISSUE.
REQ-013 SHALL stay in IDLE while no request is pending.
REQ-014 SHALL, in ISSUE and WAIT, drive MEM_READ/MEM_WRITE/MEM_BLOCK_ADDR/MEM_WRITE_DATA from the latched values only, so requester input changes are ignored.
REQ-015 SHALL go ISSUE->WAIT unconditionally after one cycle, so MEM_BUSYWAIT is never sampled in the cycle the request first appears.
REQ-016 SHALL stay in WAIT while MEM_BUSYWAIT=1, and at the first edge with MEM_BUSYWAIT=0 SHALL capture MEM_READ_DATA (reads only) into the owner's data register and enter RESP.
REQ-017 SHALL, in RESP, drive MEM_READ=MEM_WRITE=0 and return to IDLE after exactly one cycle.
REQ-018 SHALL drive IC_BUSYWAIT = IC_READ && !(state==RESP && owner==IC), and drive DC_BUSYWAIT equivalently with (DC_READ||DC_WRITE), both combinationally.
REQ-019 SHALL hold IC_READ_DATA/DC_READ_DATA stable from RESP until the next capture for that requester.
REQ-020 SHALL treat DC_READ=DC_WRITE=1 as a write.
REQ-021 SHALL complete a memory transaction even when its requester deasserts mid-transaction, and SHALL then discard the response without side effects; a re-request SHALL be arbitrated anew.
REQ-022 SHALL, by default, grant DC over IC when both request in the same IDLE cycle.
REQ-023 SHALL drive MEM_BLOCK_ADDR and MEM_WRITE_DATA to 0 in IDLE and RESP.
REQ-024 SHALL have a minimum latency from request-sampled edge N to BUSYWAIT low of 2 cycles with a zero-wait memory (RESP after edge N+2), giving back-to-back grants one IDLE cycle apart.

Reset
REQ-025 SHALL, at an edge with RESET=1, enter IDLE, clear owner/op/address registers, clear both read-data registers to 0 and abandon any in-flight transaction.
REQ-026 SHALL drive MEM_READ=MEM_WRITE=0 and MEM_BLOCK_ADDR=MEM_WRITE_DATA=0 while in reset, and SHALL keep BUSYWAITs following REQ-018.
REQ-027 SHALL give RESET priority over every other event in the same cycle.

Configuration
REQ-028 SHALL, with macro MEM_ARBITER_ROUND_ROBIN_EN defined, replace REQ-022 with round-robin: on a tie, grant the requester not granted last; the last-grant pointer resets to IC, so DC wins the first tie.
REQ-029 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, use fixed DC priority and contain no last-grant pointer.

Verification
REQ-030 SHALL cover: IC_READ=1, IC_BLOCK_ADDR=0x0000010, memory 3 wait cycles returning 0xA5..A5 -> MEM_READ high 4 cycles, addr 0x0000010, IC_BUSYWAIT low one cycle, IC_READ_DATA=0xA5..A5.
REQ-031 SHALL cover: IC_READ and DC_WRITE (addr 0x0000020, data 0x1234) asserted in the same cycle -> DC write issued first, IC read issued after DC RESP + 1 IDLE cycle; with MEM_ARBITER_ROUND_ROBIN_EN, a second tie grants IC first.
REQ-032 SHALL cover: DC write-back of addr 0x7 followed by a read of addr 0x3 -> two separate transactions, MEM_WRITE then MEM_READ, DC_BUSYWAIT low only in each RESP.
REQ-033 SHALL cover: DC_BLOCK_ADDR changed to 0x9 during WAIT -> MEM_BLOCK_ADDR stays at the latched 0x5.
REQ-034 SHALL cover: RESET pulsed during WAIT -> next cycle IDLE, MEM_READ=0, read data 0, and a fresh IC_READ served normally afterward.
REQ-035 SHALL cover: IC_READ dropped during WAIT -> transaction finishes, IC_READ_DATA unchanged, IDLE after RESP.
